// File: rtl/delayed_branch_resolver.sv
// Delayed-branch resolver: carries p0/p1 delayed branches to Stage3,
// evaluates them on N/V/Z and issues a redirect plus flush to fetch.
//
// Ports:
//   clk, rst (async, active-low)
//   advance_in                  pipeline advance from fetch
//   p0_valid_in/p0_dest_in/p0_cond_in  slot 0 delayed branch
//   p1_valid_in/p1_dest_in/p1_cond_in  slot 1 delayed branch
//   N, V, Z, flags_valid_in     Stage3 flags for the head entry
//   redirect_ready_in           fetch accepts redirect
//   redirect_valid_out          redirect pending
//   redirect_pc_out             even target pc {0,dest[W-1:1],0}
//   redirect_odd_out            target is odd half of pair
//   flush_out                   kill younger in-flight instructions
//   stall_out                   fetch must hold advance_in low
module delayed_branch_resolver #(
  parameter int PC_W         = 8,
  parameter int DEPTH        = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance_in,
  input  logic            p0_valid_in,
  input  logic [PC_W-1:0] p0_dest_in,
  input  logic [2:0]      p0_cond_in,
  input  logic            p1_valid_in,
  input  logic [PC_W-1:0] p1_dest_in,
  input  logic [2:0]      p1_cond_in,
  input  logic            N,
  input  logic            V,
  input  logic            Z,
  input  logic            flags_valid_in,
  input  logic            redirect_ready_in,
  output logic            redirect_valid_out,
  output logic [PC_W:0]   redirect_pc_out,
  output logic            redirect_odd_out,
  output logic            flush_out,
  output logic            stall_out
);

  localparam int CNT_W =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    DRAIN
  } state_t;

  typedef struct packed {
    logic            v0;
    logic [PC_W-1:0] d0;
    logic [2:0]      c0;
    logic            v1;
    logic [PC_W-1:0] d1;
    logic [2:0]      c1;
  } slot_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_t           st_q [DEPTH];
  slot_t           head;
  logic [PC_W-1:0] dest_q;
  logic            head_any;
  logic            take0, take1;
  logic            shift, load;

  function automatic logic cond_met(
    input logic [2:0] c,
    input logic       n,
    input logic       v,
    input logic       z
  );
    logic lt;
    lt = n ^ v;
    unique case (c)
      3'd0: cond_met = 1'b0;
      3'd1: cond_met = 1'b1;
      3'd2: cond_met = z;
      3'd3: cond_met = !z;
      3'd4: cond_met = lt;
      3'd5: cond_met = lt | z;
      3'd6: cond_met = !(lt | z);
      default: cond_met = !lt;
    endcase
  endfunction

  assign head     = st_q[DEPTH-1];
  assign head_any = head.v0 | head.v1;
  // p0 is the older instruction, so it wins a double take
  assign take0 = head.v0 & cond_met(head.c0, N, V, Z);
  assign take1 = head.v1 & cond_met(head.c1, N, V, Z)
               & !take0;

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    shift              = 1'b0;
    load               = 1'b0;
    redirect_valid_out = 1'b0;
    flush_out          = 1'b0;
    stall_out          = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_out = head_any & !flags_valid_in;
        if (flags_valid_in & (take0 | take1)) begin
          load    = 1'b1;
          state_d = REDIRECT;
        end else if (advance_in & !stall_out) begin
          shift = 1'b1;
        end
      end
      REDIRECT: begin
        redirect_valid_out = 1'b1;
        flush_out          = 1'b1;
        stall_out          = 1'b1;
        if (redirect_ready_in) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        flush_out = 1'b1;
        stall_out = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        dest_q <= take0 ? head.d0 : head.d1;
      end
    end
  end

  // a taken branch squashes every younger entry and the losing p1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= '0;
      end
    end else if (shift) begin
      st_q[0] <= '{v0: p0_valid_in,
                   d0: p0_dest_in,
                   c0: p0_cond_in,
                   v1: p1_valid_in,
                   d1: p1_dest_in,
                   c1: p1_cond_in};
      for (int i = 1; i < DEPTH; i++) begin
        st_q[i] <= st_q[i-1];
      end
    end
  end

  assign redirect_pc_out  = {1'b0, dest_q[PC_W-1:1], 1'b0};
  assign redirect_odd_out = dest_q[0];

endmodule

// File: tb/tb_delayed_branch_resolver.sv
// Directed bench for delayed_branch_resolver (PC_W=8, DEPTH=2,
// DRAIN_CYCLES=2) with hand-computed expectations.
module tb_delayed_branch_resolver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       advance_in = 1'b0;
  logic       p0_valid_in = 1'b0;
  logic [7:0] p0_dest_in = '0;
  logic [2:0] p0_cond_in = '0;
  logic       p1_valid_in = 1'b0;
  logic [7:0] p1_dest_in = '0;
  logic [2:0] p1_cond_in = '0;
  logic       N = 1'b0;
  logic       V = 1'b0;
  logic       Z = 1'b0;
  logic       flags_valid_in = 1'b0;
  logic       redirect_ready_in = 1'b0;
  logic       redirect_valid_out;
  logic [8:0] redirect_pc_out;
  logic       redirect_odd_out;
  logic       flush_out;
  logic       stall_out;

  int n_run  = 0;
  int n_fail = 0;

  delayed_branch_resolver dut (
    .clk               (clk),
    .rst               (rst),
    .advance_in        (advance_in),
    .p0_valid_in       (p0_valid_in),
    .p0_dest_in        (p0_dest_in),
    .p0_cond_in        (p0_cond_in),
    .p1_valid_in       (p1_valid_in),
    .p1_dest_in        (p1_dest_in),
    .p1_cond_in        (p1_cond_in),
    .N                 (N),
    .V                 (V),
    .Z                 (Z),
    .flags_valid_in    (flags_valid_in),
    .redirect_ready_in (redirect_ready_in),
    .redirect_valid_out(redirect_valid_out),
    .redirect_pc_out   (redirect_pc_out),
    .redirect_odd_out  (redirect_odd_out),
    .flush_out         (flush_out),
    .stall_out         (stall_out)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(
    input logic       v,
    input logic [7:0] d,
    input logic [2:0] c
  );
    p0_valid_in = v;
    p0_dest_in  = d;
    p0_cond_in  = c;
  endtask

  task automatic set_p1(
    input logic       v,
    input logic [7:0] d,
    input logic [2:0] c
  );
    p1_valid_in = v;
    p1_dest_in  = d;
    p1_cond_in  = c;
  endtask

  initial begin
    #3;
    chk("rst_valid", redirect_valid_out, 0);
    chk("rst_pc", redirect_pc_out, 0);
    chk("rst_odd", redirect_odd_out, 0);
    chk("rst_flush", flush_out, 0);
    chk("rst_stall", stall_out, 0);
    #4 rst = 1'b1;

    // 1: EQ with Z=1 taken, redirect after third edge
    advance_in = 1'b1;
    redirect_ready_in = 1'b1;
    flags_valid_in = 1'b1;
    Z = 1'b1;
    set_p0(1, 8'h24, 3'd2);
    step();
    set_p0(0, 8'h00, 3'd0);
    step();
    chk("t1_pre_valid", redirect_valid_out, 0);
    step();
    chk("t1_valid", redirect_valid_out, 1);
    chk("t1_pc", redirect_pc_out, 9'h024);
    chk("t1_odd", redirect_odd_out, 0);
    chk("t1_flush", flush_out, 1);
    chk("t1_stall", stall_out, 1);
    step();
    chk("t1_drain_valid", redirect_valid_out, 0);
    chk("t1_drain_flush", flush_out, 1);
    step();
    chk("t1_drain2_flush", flush_out, 1);
    step();
    chk("t1_idle_flush", flush_out, 0);
    chk("t1_idle_stall", stall_out, 0);

    // 2: NE and GT with Z=1 retire silently, LT with N=1 V=0 taken
    N = 1'b1;
    V = 1'b0;
    Z = 1'b1;
    set_p0(1, 8'h40, 3'd3);
    step();
    set_p0(1, 8'h44, 3'd6);
    step();
    chk("t2_ne_silent", redirect_valid_out, 0);
    set_p0(1, 8'h08, 3'd4);
    step();
    chk("t2_gt_silent", redirect_valid_out, 0);
    set_p0(0, 8'h00, 3'd0);
    step();
    chk("t2_lt_pre", redirect_valid_out, 0);
    step();
    chk("t2_valid", redirect_valid_out, 1);
    chk("t2_pc", redirect_pc_out, 9'h008);
    chk("t2_odd", redirect_odd_out, 0);
    repeat (3) step();
    chk("t2_idle", flush_out, 0);

    // 3: p0 and p1 both AL, p0 wins, p1 dropped
    N = 1'b0;
    Z = 1'b0;
    set_p0(1, 8'h10, 3'd1);
    set_p1(1, 8'h31, 3'd1);
    step();
    set_p0(0, 8'h00, 3'd0);
    set_p1(0, 8'h00, 3'd0);
    step();
    step();
    chk("t3_valid", redirect_valid_out, 1);
    chk("t3_pc", redirect_pc_out, 9'h010);
    chk("t3_odd", redirect_odd_out, 0);
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_p1_dropped", redirect_valid_out, 0);
    end

    // 4: p1 alone, odd destination
    set_p1(1, 8'h31, 3'd1);
    step();
    set_p1(0, 8'h00, 3'd0);
    step();
    step();
    chk("t4_valid", redirect_valid_out, 1);
    chk("t4_pc", redirect_pc_out, 9'h030);
    chk("t4_odd", redirect_odd_out, 1);
    repeat (3) step();

    // 5: back-pressure holds redirect and ignores captures
    redirect_ready_in = 1'b0;
    set_p0(1, 8'h20, 3'd1);
    step();
    set_p0(0, 8'h00, 3'd0);
    step();
    step();
    chk("t5_valid", redirect_valid_out, 1);
    set_p0(1, 8'h50, 3'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_valid", redirect_valid_out, 1);
      chk("t5_hold_pc", redirect_pc_out, 9'h020);
    end
    set_p0(0, 8'h00, 3'd0);
    redirect_ready_in = 1'b1;
    step();
    chk("t5_d1_flush", flush_out, 1);
    chk("t5_d1_valid", redirect_valid_out, 0);
    step();
    chk("t5_d2_flush", flush_out, 1);
    step();
    chk("t5_idle_flush", flush_out, 0);
    flags_valid_in = 1'b0;
    advance_in = 1'b0;
    #1;
    chk("t5_stages_empty", stall_out, 0);
    flags_valid_in = 1'b1;
    advance_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_capture", redirect_valid_out, 0);
    end

    // 6: flags not valid stalls the head, then reset mid-redirect
    flags_valid_in = 1'b0;
    set_p0(1, 8'h3A, 3'd1);
    step();
    set_p0(0, 8'h00, 3'd0);
    step();
    chk("t6_stall", stall_out, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stall_hold", stall_out, 1);
      chk("t6_no_redirect", redirect_valid_out, 0);
    end
    flags_valid_in = 1'b1;
    #1;
    chk("t6_unstall", stall_out, 0);
    step();
    chk("t6_valid", redirect_valid_out, 1);
    chk("t6_pc", redirect_pc_out, 9'h03A);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_valid", redirect_valid_out, 0);
    chk("t6_rst_pc", redirect_pc_out, 0);
    chk("t6_rst_flush", flush_out, 0);
    chk("t6_rst_stall", stall_out, 0);
    chk("t6_rst_odd", redirect_odd_out, 0);
    step();
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
